// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and FSM states shared by the alu_seq slice
// Contents: op_e (8 opcodes), state_e (IDLE/SHIFT/DONE), FLAG_Z/V/N indices, is_shift()
package alu_pkg;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_NAND, OP_XOR, OP_INC, OP_SRA, OP_SRL, OP_SLL} op_e;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;
    function automatic logic is_shift(op_e op);
        return op inside {OP_SRA, OP_SRL, OP_SLL};
    endfunction
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response handshake bundle between an issuer and alu_seq
// Request: in_valid, in_ready, op, a, b, shamt. Response: out_valid, out_ready, result, flags, busy.
interface alu_seq_if import alu_pkg::*; #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) ();
    logic               in_valid;
    logic               in_ready;
    op_e                op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic [2:0]         flags;
    logic               busy;
    modport master (output in_valid, op, a, b, shamt, out_ready,
                    input  in_ready, out_valid, result, flags, busy);
    modport slave  (input  in_valid, op, a, b, shamt, out_ready,
                    output in_ready, out_valid, result, flags, busy);
endinterface

// File: rtl/alu_seq_core.sv
// alu_seq_core: single-cycle arith/logic/barrel datapath with [Z,V,N] flag computation
// Ports: op_i, a_i, b_i, shamt_i, flags_i (current flags) -> res_o, flags_o (next flags)
module alu_seq_core import alu_pkg::*; #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  op_e                op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [2:0]         flags_i,
    output logic [WIDTH-1:0]   res_o,
    output logic [2:0]         flags_o
);
    localparam int M = WIDTH - 1;
    logic [WIDTH-1:0] sum;
    logic             sub, ovf, arith;
    assign sub   = op_i == OP_SUB;
    assign arith = op_i inside {OP_ADD, OP_SUB, OP_INC};
    assign sum   = sub ? a_i - b_i : a_i + b_i;
    assign ovf   = (sub ? a_i[M] != b_i[M] : a_i[M] == b_i[M]) && (sum[M] != a_i[M]);
    always_comb begin
        res_o   = sum;
        flags_o = flags_i;
        case (op_i)
            OP_NAND: res_o = ~(a_i & b_i);
            OP_XOR:  res_o = a_i ^ b_i;
            OP_SRA:  res_o = $signed(a_i) >>> shamt_i;
            OP_SRL:  res_o = a_i >> shamt_i;
            OP_SLL:  res_o = a_i << shamt_i;
            default: res_o = sum;
        endcase
        // shifts leave the flag register untouched; logic ops clear V and N
        if (!is_shift(op_i)) begin
            flags_o[FLAG_Z] = res_o == '0;
            flags_o[FLAG_V] = arith && ovf;
            flags_o[FLAG_N] = arith && res_o[M];
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result, persistent flags and optional bit-serial shifter
// Ports: clk, rst_n (async active-low), bus (alu_seq_if.slave: in_valid/in_ready/op/a/b/shamt in,
//        out_valid/out_ready/result/flags/busy out)
module alu_seq import alu_pkg::*; #(
    parameter int WIDTH      = 16,
    parameter int SHAMT_W    = $clog2(WIDTH),
    parameter int SHIFT_ITER = 1
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam int M = WIDTH - 1;
    state_e             state_q;
    op_e                op_q;
    logic [WIDTH-1:0]   wrk_q, wrk_d, result_q, core_res;
    logic [SHAMT_W-1:0] cnt_q;
    logic [2:0]         flags_q, core_flags;
    logic               accept, iter;
    alu_seq_core #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_core (
        .op_i(bus.op), .a_i(bus.a), .b_i(bus.b), .shamt_i(bus.shamt),
        .flags_i(flags_q), .res_o(core_res), .flags_o(core_flags)
    );
    assign bus.in_ready  = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    // zero-length shifts take the single-cycle path even when iterating
    assign iter          = (SHIFT_ITER != 0) && is_shift(bus.op) && (bus.shamt != '0);
    assign wrk_d         = op_q == OP_SRA ? {wrk_q[M], wrk_q[M:1]} :
                           op_q == OP_SRL ? {1'b0, wrk_q[M:1]} : {wrk_q[M-1:0], 1'b0};
    assign bus.out_valid = state_q == DONE;
    assign bus.busy      = state_q == SHIFT;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            wrk_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else if (state_q == SHIFT) begin
            wrk_q <= wrk_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == SHAMT_W'(1)) begin
                result_q <= wrk_d;
                state_q  <= DONE;
            end
        end else if (accept) begin
            op_q <= bus.op;
            if (iter) begin
                wrk_q   <= bus.a;
                cnt_q   <= bus.shamt;
                state_q <= SHIFT;
            end else begin
                result_q <= core_res;
                flags_q  <= core_flags;
                state_q  <= DONE;
            end
        end else if (state_q != DONE || bus.out_ready) begin
            // also recovers the unused state encoding
            state_q <= IDLE;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (16-bit iterative and 32-bit barrel instances)
module tb_alu_seq;
    import alu_pkg::*;
    typedef struct {
        logic [31:0] res;
        logic [2:0]  fl;
        int          acc;
        int          lat;
    } exp_t;
    logic clk = 0;
    logic rst_n = 0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   last_wait = 0;
    bit   rnd_ready = 0;
    bit   seen [2];
    logic [2:0] mfl [2];
    exp_t q0[$];
    exp_t q1[$];
    alu_seq_if #(.WIDTH(16)) b16 ();
    alu_seq_if #(.WIDTH(32)) b32 ();
    alu_seq #(.WIDTH(16), .SHIFT_ITER(1)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
    alu_seq #(.WIDTH(32), .SHIFT_ITER(0)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [34:0] model(int op, logic [31:0] a, logic [31:0] b, int sh, int w, logic [2:0] fl);
        longint m, ua, ub, sa, sb, t, r;
        logic [2:0] f;
        m  = (longint'(1) << w) - 1;
        ua = longint'(a) & m;
        ub = longint'(b) & m;
        sa = ua[w-1] ? ua - (m + 1) : ua;
        sb = ub[w-1] ? ub - (m + 1) : ub;
        f  = fl;
        t  = 0;
        case (op)
            0, 4:    t = sa + sb;
            1:       t = sa - sb;
            default: t = 0;
        endcase
        case (op)
            2:       r = ~(ua & ub) & m;
            3:       r = ua ^ ub;
            5:       r = (sa >>> sh) & m;
            6:       r = ua >> sh;
            7:       r = (ua << sh) & m;
            default: r = t & m;
        endcase
        if (op == 0 || op == 1 || op == 4) f = {r == 0, t > (m >> 1) || t < -(m >> 1) - 1, r[w-1]};
        else if (op == 2 || op == 3) f = {r == 0, 2'b00};
        return {f, r[31:0]};
    endfunction
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask
    task automatic mon(int w);
        logic ov, ordy;
        logic [31:0] res;
        logic [2:0] fl;
        exp_t e;
        int n;
        ov   = w ? b32.out_valid : b16.out_valid;
        ordy = w ? b32.out_ready : b16.out_ready;
        res  = w ? b32.result : {16'h0, b16.result};
        fl   = w ? b32.flags : b16.flags;
        n    = w ? q1.size() : q0.size();
        if (!ov) return;
        if (n == 0) begin
            chk($sformatf("spurious_out_valid%0d", w), 32'(ov), 32'd0);
            return;
        end
        e = w ? q1[0] : q0[0];
        if (!seen[w]) begin
            chk($sformatf("latency%0d", w), 32'(cyc), 32'(e.acc + e.lat - 1));
            seen[w] = 1;
        end
        if (ordy) begin
            chk($sformatf("result%0d", w), res, e.res);
            chk($sformatf("flags%0d", w), 32'(fl), 32'(e.fl));
            if (w) void'(q1.pop_front());
            else void'(q0.pop_front());
            seen[w] = 0;
        end
    endtask
    initial forever begin
        @(negedge clk);
        #1;
        mon(0);
        mon(1);
    end
    initial forever begin
        @(negedge clk);
        if (rnd_ready) begin
            b16.out_ready = ($urandom % 4) != 0;
            b32.out_ready = ($urandom % 4) != 0;
        end
    end
    task automatic issue(int w, int op, logic [31:0] a, logic [31:0] b, int sh);
        int n;
        logic [34:0] m;
        exp_t e;
        if (w) begin
            b32.in_valid = 1; b32.op = op_e'(op); b32.a = a; b32.b = b; b32.shamt = 5'(sh);
        end else begin
            b16.in_valid = 1; b16.op = op_e'(op); b16.a = a[15:0]; b16.b = b[15:0]; b16.shamt = 4'(sh);
        end
        #1;
        n = 0;
        while (!(w ? b32.in_ready : b16.in_ready) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        last_wait = n;
        if (n >= 100) begin
            chk($sformatf("accept_timeout%0d", w), 32'(n), 32'd0);
        end else begin
            m = model(op, a, b, sh, w ? 32 : 16, mfl[w]);
            mfl[w] = m[34:32];
            e.res = m[31:0];
            e.fl  = m[34:32];
            e.acc = cyc + 1;
            e.lat = (w == 0 && op >= 5 && sh != 0) ? sh + 1 : 1;
            if (w) q1.push_back(e);
            else q0.push_back(e);
        end
        @(negedge clk);
        if (w) b32.in_valid = 0;
        else b16.in_valid = 0;
    endtask
    task automatic drain();
        int n;
        #1;
        rnd_ready = 0;
        b16.out_ready = 1;
        b32.out_ready = 1;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'(q0.size() + q1.size()), 32'd0);
        @(negedge clk);
    endtask
    initial begin
        int bc, w;
        b16.in_valid = 0; b16.op = OP_ADD; b16.a = '0; b16.b = '0; b16.shamt = '0; b16.out_ready = 1;
        b32.in_valid = 0; b32.op = OP_ADD; b32.a = '0; b32.b = '0; b32.shamt = '0; b32.out_ready = 1;
        mfl[0] = '0; mfl[1] = '0;
        repeat (2) @(negedge clk);
        chk("rst_result16", 32'(b16.result), 32'd0);
        chk("rst_flags16", 32'(b16.flags), 32'd0);
        chk("rst_out_valid16", 32'(b16.out_valid), 32'd0);
        chk("rst_busy16", 32'(b16.busy), 32'd0);
        chk("rst_in_ready16", 32'(b16.in_ready), 32'd1);
        chk("rst_result32", b32.result, 32'd0);
        rst_n = 1;
        @(negedge clk);
        issue(0, 0, 32'h7FFF, 32'h0001, 0);
        issue(0, 1, 32'h1234, 32'h1234, 0);
        issue(0, 3, 32'hFFFF, 32'h0F0F, 0);
        drain();
        issue(0, 5, 32'h8000, 32'h0, 15);
        bc = 0;
        repeat (20) begin
            if (b16.busy) bc++;
            @(negedge clk);
        end
        chk("sra15_busy_cycles", 32'(bc), 32'd15);
        drain();
        issue(0, 5, 32'h8000, 32'h0, 0);
        drain();
        b16.out_ready = 0;
        issue(0, 4, 32'hFFFF, 32'h0001, 0);
        repeat (5) begin
            chk("bp_result", 32'(b16.result), 32'h0000);
            chk("bp_flags", 32'(b16.flags), 32'b100);
            chk("bp_in_ready", 32'(b16.in_ready), 32'd0);
            chk("bp_out_valid", 32'(b16.out_valid), 32'd1);
            @(negedge clk);
        end
        b16.out_ready = 1;
        #1;
        chk("bp_release_in_ready", 32'(b16.in_ready), 32'd1);
        issue(0, 0, 32'h0001, 32'h0002, 0);
        chk("bp_same_cycle_accept", 32'(last_wait), 32'd0);
        drain();
        issue(0, 7, 32'h0123, 32'h0, 10);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("midrst_result", 32'(b16.result), 32'd0);
        chk("midrst_flags", 32'(b16.flags), 32'd0);
        chk("midrst_out_valid", 32'(b16.out_valid), 32'd0);
        chk("midrst_busy", 32'(b16.busy), 32'd0);
        q0.delete(); q1.delete();
        mfl[0] = '0; mfl[1] = '0;
        seen[0] = 0; seen[1] = 0;
        @(negedge clk);
        rst_n = 1;
        repeat (20) @(negedge clk);
        chk("postrst_out_valid", 32'(b16.out_valid), 32'd0);
        chk("postrst_in_ready", 32'(b16.in_ready), 32'd1);
        issue(1, 6, 32'h80000000, 32'h0, 31);
        issue(1, 0, 32'h80000000, 32'h80000000, 0);
        drain();
        rnd_ready = 1;
        for (int i = 0; i < 160; i++) begin
            w = int'($urandom % 2);
            issue(w, int'($urandom % 8), $urandom, (i % 5 == 0) ? 32'h1 : $urandom,
                  w ? int'($urandom % 32) : int'($urandom % 16));
            repeat ($urandom % 3) @(negedge clk);
        end
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
